// File: rtl/addsub_pkg.sv
// Shared encodings and helpers for the serial add/subtract unit.
// Saturation limits are produced for widths up to 64 bits.
package addsub_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic carry;
        logic ovf;
        logic zero;
    } flags_t;

    // sign=1 selects the most negative value, sign=0 the most positive one.
    function automatic logic [63:0] sat_value(input logic sign, input int unsigned width);
        logic [63:0] msb;
        msb = 64'd1 << (width - 1);
        return sign ? msb : (msb - 64'd1);
    endfunction

endpackage

// File: rtl/addsub_digit.sv
// DIGIT-bit ripple adder slice; purely combinational, zero latency, no flow control.
// Also exposes the carry into its MSB so the caller can derive signed overflow.
module addsub_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout,
    output logic             c_msb_in
);

    always_comb begin
        logic c;
        s        = '0;
        c_msb_in = 1'b0;
        c        = cin;
        for (int i = 0; i < DIGIT; i++) begin
            if (i == DIGIT - 1) c_msb_in = c;
            s[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial add/subtract, LSB first; result valid WIDTH/DIGIT cycles after accept.
// Accepts only in IDLE, holds result in DONE until out_ready; SERIAL_ADDSUB_SATURATE_EN clamps on overflow.
module serial_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int NDIG  = WIDTH / DIGIT;
    localparam int CNT_W = $clog2(NDIG) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NDIG - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_sh, b_sh, acc, acc_nxt, s_ext, final_res;
    logic             c, op_q;
    logic [DIGIT-1:0] dsum;
    logic             dcout, dcmsb;
    logic             accept, last;
    flags_t           flags;

    addsub_digit #(.DIGIT(DIGIT)) u_digit (
        .x        (a_sh[DIGIT-1:0]),
        .y        (b_sh[DIGIT-1:0]),
        .cin      (c),
        .s        (dsum),
        .cout     (dcout),
        .c_msb_in (dcmsb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = S_RUN;
            end
            S_RUN: begin
                if (cnt == LAST) state_nxt = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign accept = (state == S_IDLE) && in_valid;
    assign last   = (state == S_RUN) && (cnt == LAST);

    // New digit enters at the top so after NDIG shifts the word is LSB-aligned.
    always_comb begin
        s_ext             = '0;
        s_ext[DIGIT-1:0]  = dsum;
        acc_nxt           = (acc >> DIGIT) | (s_ext << (WIDTH - DIGIT));
        flags.ovf         = dcmsb ^ dcout;
        flags.carry       = dcout ^ op_q;
`ifdef SERIAL_ADDSUB_SATURATE_EN
        // On the last digit a_sh[DIGIT-1] is still the original sign of a.
        final_res = flags.ovf ? WIDTH'(sat_value(a_sh[DIGIT-1], WIDTH)) : acc_nxt;
`else
        final_res = acc_nxt;
`endif
        flags.zero        = (final_res == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh      <= '0;
            b_sh      <= '0;
            acc       <= '0;
            c         <= 1'b0;
            op_q      <= OP_ADD;
            cnt       <= '0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
        end else if (accept) begin
            a_sh <= a;
            b_sh <= b ^ {WIDTH{op}};
            c    <= carry_in ^ op;
            op_q <= op;
            cnt  <= '0;
        end else if (state == S_RUN) begin
            a_sh <= a_sh >> DIGIT;
            b_sh <= b_sh >> DIGIT;
            acc  <= acc_nxt;
            c    <= dcout;
            cnt  <= cnt + CNT_W'(1);
            if (last) begin
                result    <= final_res;
                carry_out <= flags.carry;
                overflow  <= flags.ovf;
                zero      <= flags.zero;
            end
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Drives four serial_addsub configurations in lockstep and compares them to an integer arithmetic model.
module tb_serial_addsub;

    typedef struct packed {
        logic [15:0] res;
        logic        co;
        logic        ov;
        logic        z;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        op_i = 1'b0;
    logic [15:0] a_i = '0;
    logic [15:0] b_i = '0;
    logic        cin_i = 1'b0;
    logic        out_ready = 1'b0;

    logic [7:0]  r8;
    logic [15:0] r16a, r16b, r16c;
    logic [15:0] res_a [4];
    logic        co_a [4], ov_a [4], z_a [4], ovd_a [4], ir_a [4];

    int n_checks = 0;
    int n_errors = 0;
    int widths  [4] = '{8, 16, 16, 16};
    int lat_exp [4] = '{2, 16, 4, 1};

    always #5 clk = ~clk;

    serial_addsub #(.WIDTH(8), .DIGIT(4)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_a[0]), .op(op_i),
        .a(a_i[7:0]), .b(b_i[7:0]), .carry_in(cin_i), .out_valid(ovd_a[0]), .out_ready(out_ready),
        .result(r8), .carry_out(co_a[0]), .overflow(ov_a[0]), .zero(z_a[0]));
    serial_addsub #(.WIDTH(16), .DIGIT(1)) u16a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_a[1]), .op(op_i),
        .a(a_i), .b(b_i), .carry_in(cin_i), .out_valid(ovd_a[1]), .out_ready(out_ready),
        .result(r16a), .carry_out(co_a[1]), .overflow(ov_a[1]), .zero(z_a[1]));
    serial_addsub #(.WIDTH(16), .DIGIT(4)) u16b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_a[2]), .op(op_i),
        .a(a_i), .b(b_i), .carry_in(cin_i), .out_valid(ovd_a[2]), .out_ready(out_ready),
        .result(r16b), .carry_out(co_a[2]), .overflow(ov_a[2]), .zero(z_a[2]));
    serial_addsub #(.WIDTH(16), .DIGIT(16)) u16c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_a[3]), .op(op_i),
        .a(a_i), .b(b_i), .carry_in(cin_i), .out_valid(ovd_a[3]), .out_ready(out_ready),
        .result(r16c), .carry_out(co_a[3]), .overflow(ov_a[3]), .zero(z_a[3]));

    assign res_a[0] = {8'h00, r8};
    assign res_a[1] = r16a;
    assign res_a[2] = r16b;
    assign res_a[3] = r16c;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Plain integer arithmetic: a +/- b +/- cin, both unsigned and signed views.
    function automatic exp_t model(input int w, input logic op, input logic [15:0] a,
                                   input logic [15:0] b, input logic cin);
        exp_t   e;
        longint md, hf, ua, ub, sa, sb, ur, sr, ci;
        md = longint'(1) << w;
        hf = md / 2;
        ua = longint'(a) & (md - 1);
        ub = longint'(b) & (md - 1);
        sa = (ua >= hf) ? ua - md : ua;
        sb = (ub >= hf) ? ub - md : ub;
        ci = cin ? 1 : 0;
        if (op) begin
            ur   = ua - ub - ci;
            sr   = sa - sb - ci;
            e.co = (ua < ub + ci);
        end else begin
            ur   = ua + ub + ci;
            sr   = sa + sb + ci;
            e.co = (ur >= md);
        end
        e.ov  = (sr >= hf) || (sr < -hf);
        e.res = 16'(ur & (md - 1));
`ifdef SERIAL_ADDSUB_SATURATE_EN
        if (e.ov) e.res = (sr > 0) ? 16'(hf - 1) : 16'(hf);
`endif
        e.z = (e.res == 16'd0);
        return e;
    endfunction

    task automatic run_txn(input logic op, input logic [15:0] a, input logic [15:0] b,
                           input logic cin, input int hold);
        int   lat [4];
        bit   all_done;
        exp_t e;
        @(negedge clk);
        check("idle_in_ready", {ir_a[0], ir_a[1], ir_a[2], ir_a[3]}, 4'hF);
        op_i = op; a_i = a; b_i = b; cin_i = cin; in_valid = 1'b1;
        @(posedge clk);
        #1;
        // Scramble the inputs after accept: results must come from the sampled operands.
        in_valid = 1'b0; op_i = ~op; a_i = 16'($urandom); b_i = 16'($urandom); cin_i = ~cin;
        lat = '{-1, -1, -1, -1};
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk);
            #1;
            all_done = 1'b1;
            for (int i = 0; i < 4; i++) begin
                if (ovd_a[i] && lat[i] < 0) lat[i] = cyc;
                if (lat[i] < 0) all_done = 1'b0;
            end
            if (all_done) break;
        end
        for (int i = 0; i < 4; i++) begin
            e = model(widths[i], op, a, b, cin);
            check($sformatf("latency[%0d] op=%0d a=%h b=%h", i, op, a, b), 64'(lat[i]), 64'(lat_exp[i]));
            check($sformatf("result[%0d] op=%0d a=%h b=%h c=%0d", i, op, a, b, cin), 64'(res_a[i]), 64'(e.res));
            check($sformatf("carry_out[%0d] op=%0d a=%h b=%h c=%0d", i, op, a, b, cin), 64'(co_a[i]), 64'(e.co));
            check($sformatf("overflow[%0d] op=%0d a=%h b=%h c=%0d", i, op, a, b, cin), 64'(ov_a[i]), 64'(e.ov));
            check($sformatf("zero[%0d] op=%0d a=%h b=%h c=%0d", i, op, a, b, cin), 64'(z_a[i]), 64'(e.z));
        end
        e = model(8, op, a, b, cin);
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1; a_i = 16'($urandom); b_i = 16'($urandom); op_i = 1'($urandom);
            @(posedge clk);
            #1;
            check("bp_result", 64'(res_a[0]), 64'(e.res));
            check("bp_flags", {co_a[0], ov_a[0], z_a[0]}, {e.co, e.ov, e.z});
            check("bp_in_ready", 64'(ir_a[0]), 64'd0);
            check("bp_out_valid", 64'(ovd_a[0]), 64'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("post_handshake_in_ready", {ir_a[0], ir_a[1], ir_a[2], ir_a[3]}, 4'hF);
        check("post_handshake_out_valid", {ovd_a[0], ovd_a[1], ovd_a[2], ovd_a[3]}, 4'h0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rst_result[%0d]", i), 64'(res_a[i]), 64'd0);
            check($sformatf("rst_flags[%0d]", i), {co_a[i], ov_a[i], z_a[i]}, 3'b000);
            check($sformatf("rst_out_valid[%0d]", i), 64'(ovd_a[i]), 64'd0);
            check($sformatf("rst_in_ready[%0d]", i), 64'(ir_a[i]), 64'd1);
        end
        @(negedge clk);
        rst_n = 1'b1;

        run_txn(1'b1, 16'h000A, 16'h0004, 1'b0, 0);
        run_txn(1'b1, 16'h000A, 16'h000F, 1'b0, 0);
        run_txn(1'b1, 16'h00F6, 16'h00FD, 1'b0, 0);
        run_txn(1'b1, 16'h000A, 16'h000A, 1'b0, 0);
        run_txn(1'b1, 16'h0080, 16'h0001, 1'b0, 0);
        run_txn(1'b1, 16'h8000, 16'h0001, 1'b0, 0);
        run_txn(1'b0, 16'h007F, 16'h0001, 1'b0, 5);
        run_txn(1'b0, 16'h7FFF, 16'h0001, 1'b0, 0);
        run_txn(1'b0, 16'h00FF, 16'h0001, 1'b1, 0);
        run_txn(1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 0);
        run_txn(1'b1, 16'h0000, 16'h0000, 1'b1, 0);

        // Abort mid-operation: leave a nonzero result, start another, reset during RUN.
        run_txn(1'b0, 16'h007F, 16'h0001, 1'b0, 0);
        @(negedge clk);
        op_i = 1'b0; a_i = 16'h0003; b_i = 16'h0005; cin_i = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("abort_result[%0d]", i), 64'(res_a[i]), 64'd0);
            check($sformatf("abort_flags[%0d]", i), {co_a[i], ov_a[i], z_a[i]}, 3'b000);
            check($sformatf("abort_out_valid[%0d]", i), 64'(ovd_a[i]), 64'd0);
            check($sformatf("abort_in_ready[%0d]", i), 64'(ir_a[i]), 64'd1);
        end
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 40; k++) begin
            run_txn(1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
